pmcc_code_ram_arbiter: RTL and testbench
========================================

PMCC_CODE_RAM_ARBITER -- requirements
Module: pmcc_code_ram_arbiter

Interface
REQ-001 Parameter PROTECT_EN, default 1: when 1, host writes are blocked while the PMC core runs.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 core_halted  input  1  1 = PMC core halted, so host code writes are permitted.
REQ-005 m0_req / m0_we  input  1 / 1  host (SoC) request and write enable.
REQ-006 m0_addr / m0_wdata  input  32 / 32  host address and write data.
REQ-007 m0_be  input  4  host byte enables.
REQ-008 m0_gnt / m0_rvalid / m0_err  output  1 / 1 / 1  host grant, response valid and response error.
REQ-009 m0_rdata  output  32  host read data.
REQ-010 m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_err, m1_rdata  same widths and directions as the m0 ports  PMC core LSU port.
REQ-011 s_req / s_we  output  1 / 1  code RAM request and write enable.
REQ-012 s_addr / s_wdata  output  32 / 32  code RAM address and write data.
REQ-013 s_be  output  4  code RAM byte enables.
REQ-014 s_gnt / s_rvalid / s_err  input  1 / 1 / 1  code RAM grant, response valid and error.
REQ-015 s_rdata  input  32  code RAM read data.

Function
REQ-016 Arbitration is combinational in the request cycle: one requester wins per cycle. A lone requester wins. If both request, the winner is the master that is not last_winner (round-robin).
REQ-017 last_winner is a 1-bit register, updated to the winner index on every completed handshake (grant issued). It holds otherwise.
REQ-018 Forwarded access: s_req=1 and s_addr/s_we/s_be/s_wdata come from the winner. The winner's mX_gnt = s_gnt. The loser's gnt = 0.
REQ-019 When there is no request, s_req=0 and the s_* payload is 0.
REQ-020 Blocked access: PROTECT_EN=1, winner is m0, m0_we=1, core_halted=0.
  - s_req=0 and m0_gnt=1 in the same cycle.
  - The code RAM is never written.
REQ-021 Response routing: on every handshake, register resp_owner (1 bit) and resp_blocked (1 bit) and set resp_pending=1. Otherwise resp_pending clears.
REQ-022 The cycle after a forwarded handshake, mX_rvalid=s_rvalid for X=resp_owner, with mX_rdata=s_rdata and mX_err=s_err. The other master's rvalid=0.
REQ-023 The cycle after a blocked handshake: m0_rvalid=1, m0_err=1, m0_rdata=0, with s_rvalid ignored.
REQ-024 Non-owner rdata=0 and err=0; rvalid is never asserted to both masters in one cycle.
REQ-025 Back-to-back handshakes every cycle are supported; throughput is 1 access/cycle and response latency is exactly 1 cycle.
REQ-026 s_rvalid arriving with resp_pending=0 is dropped; no master sees rvalid.
REQ-027 core_halted is sampled only in the request cycle. A change between grant and response does not alter an already-issued response.
REQ-028 m0 reads and m1 accesses are never blocked, whatever the value of core_halted.

Reset
REQ-029 On rst_n=0, asynchronously:
  - last_winner=1, so m0 wins the first contention.
  - resp_pending=0, resp_owner=0, resp_blocked=0.
REQ-030 During and immediately after reset, all rvalid, err and rdata outputs are 0.
REQ-031 Grants follow REQ-016..020 combinationally even during reset, but state is not updated until rst_n=1.
REQ-032 Reset asserted with a response pending discards that response; no rvalid is issued after release.

Verification
REQ-033 Reset release, both masters request a read of addr 0x10 in the same cycle, s_gnt=1 -> m0 granted. Next cycle m0_rvalid=1 with s_rdata=0xDEADBEEF. m1 granted in the following cycle.
REQ-034 Both masters request continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1 and each rvalid goes to the matching owner one cycle later.
REQ-035 core_halted=0, m0 writes 0x12345678 to 0x04 -> m0_gnt=1, s_req=0, next cycle m0_rvalid=1 and m0_err=1. A subsequent read of 0x04 returns the old value.
REQ-036 core_halted=1, m0 writes 0x12345678 to 0x04 then reads 0x04 -> s_req asserted with be=0xF and err=0. Read returns 0x12345678.
REQ-037 PROTECT_EN=0, core_halted=0, m0 write -> forwarded normally with err=0.
REQ-038 rst_n pulsed low in the cycle after an m1 handshake -> no m1_rvalid is issued, and the next contention is won by m0.

Source files
------------

// File: rtl/pmcc_code_ram_arbiter.sv
// pmcc_code_ram_arbiter: two-master, single-slave arbiter in front of the PMC code RAM.
//   m0_* : host (SoC) request/response port
//   m1_* : PMC core LSU request/response port
//   s_*  : code RAM port
//   core_halted : PMC core halted; when PROTECT_EN, host writes are only forwarded while halted
// Arbitration is combinational and round-robin on contention. Each granted access gets
// its response exactly one cycle later. A blocked host write is granted locally, never
// reaches the RAM, and is answered with an error response.
module pmcc_code_ram_arbiter #(
  parameter bit PROTECT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_halted,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic        s_err,
  input  logic [31:0] s_rdata
);

  localparam int unsigned DW = 32;

  logic last_winner;
  logic resp_pending;
  logic resp_owner;
  logic resp_blocked;

  logic any_req;
  logic winner;
  logic blocked;
  logic win_gnt;

  // Request-cycle arbitration, write protection and payload forwarding.
  always_comb begin
    any_req = m0_req | m1_req;
    winner  = 1'b0;
    if (m0_req && m1_req) begin
      winner = ~last_winner;
    end else if (m1_req) begin
      winner = 1'b1;
    end

    blocked = PROTECT_EN && any_req && !winner && m0_we && !core_halted;

    s_req   = any_req && !blocked;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_be    = '0;
    if (s_req) begin
      s_we    = winner ? m1_we    : m0_we;
      s_addr  = winner ? m1_addr  : m0_addr;
      s_wdata = winner ? m1_wdata : m0_wdata;
      s_be    = winner ? m1_be    : m0_be;
    end

    // Blocked writes complete locally, independent of the RAM grant.
    win_gnt = blocked | (s_req & s_gnt);
    m0_gnt  = win_gnt & ~winner;
    m1_gnt  = win_gnt &  winner;
  end

  // Response routing to the owner of the previous cycle's handshake.
  always_comb begin
    m0_rvalid = resp_pending && !resp_owner && (resp_blocked || s_rvalid);
    m1_rvalid = resp_pending &&  resp_owner && !resp_blocked && s_rvalid;
    m0_err    = m0_rvalid && (resp_blocked || s_err);
    m1_err    = m1_rvalid && s_err;
    m0_rdata  = (m0_rvalid && !resp_blocked) ? s_rdata : DW'(0);
    m1_rdata  = m1_rvalid ? s_rdata : DW'(0);
  end

  // Handshake bookkeeping; last_winner resets to 1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner  <= 1'b1;
      resp_pending <= 1'b0;
      resp_owner   <= 1'b0;
      resp_blocked <= 1'b0;
    end else begin
      resp_pending <= win_gnt;
      if (win_gnt) begin
        last_winner  <= winner;
        resp_owner   <= winner;
        resp_blocked <= blocked;
      end
    end
  end

endmodule

// File: tb/tb_pmcc_code_ram_arbiter.sv
// Scoreboard bench for pmcc_code_ram_arbiter: a behavioural code RAM answers the DUT,
// a reference model predicts grants/payload and queues expected responses.
module tb_pmcc_code_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_halted = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_gnt = 1'b1;
  logic        s_rvalid = 1'b0, s_err = 1'b0;
  logic [31:0] s_rdata = 0;
  logic        spur = 1'b0;

  // Second instance with protection disabled; only its m0 port is exercised.
  logic        u1_m0_gnt, u1_m0_rvalid, u1_m0_err, u1_m1_gnt, u1_m1_rvalid, u1_m1_err;
  logic [31:0] u1_m0_rdata, u1_m1_rdata, u1_s_addr, u1_s_wdata;
  logic        u1_s_req, u1_s_we;
  logic [3:0]  u1_s_be;
  logic        u1_s_rvalid = 1'b0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic [3:0]  zero4 = 4'h0;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  typedef struct {
    int unsigned cyc;
    logic        owner;
    logic        blk;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t q[$];

  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  logic        lw_m = 1'b1;
  logic        u1_exp = 1'b0;

  always #5 clk = ~clk;

  pmcc_code_ram_arbiter #(.PROTECT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .core_halted(core_halted),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata)
  );

  pmcc_code_ram_arbiter #(.PROTECT_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .core_halted(core_halted),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(u1_m0_gnt), .m0_rvalid(u1_m0_rvalid), .m0_err(u1_m0_err), .m0_rdata(u1_m0_rdata),
    .m1_req(zero1), .m1_we(zero1), .m1_addr(zero32), .m1_wdata(zero32), .m1_be(zero4),
    .m1_gnt(u1_m1_gnt), .m1_rvalid(u1_m1_rvalid), .m1_err(u1_m1_err), .m1_rdata(u1_m1_rdata),
    .s_req(u1_s_req), .s_we(u1_s_we), .s_addr(u1_s_addr), .s_wdata(u1_s_wdata), .s_be(u1_s_be),
    .s_gnt(s_gnt), .s_rvalid(u1_s_rvalid), .s_err(zero1), .s_rdata(zero32)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  // Behavioural code RAM: responds one cycle after each accepted request.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
      s_rvalid <= 1'b0;
      s_err    <= 1'b0;
      s_rdata  <= 32'h0;
    end else begin
      s_rvalid <= (s_req && s_gnt) || spur;
      if (s_req && s_gnt) begin
        s_err   <= s_addr[8];
        s_rdata <= (s_we || s_addr[8]) ? 32'h0 : ram[s_addr[7:2]];
        if (s_we && !s_addr[8])
          for (int i = 0; i < 4; i++)
            if (s_be[i]) ram[s_addr[7:2]][8*i +: 8] <= s_wdata[8*i +: 8];
      end else begin
        s_err   <= 1'b1;
        s_rdata <= 32'hBAD0BAD0;
      end
    end
  end

  always @(posedge clk) u1_s_rvalid <= u1_s_req && s_gnt;

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic        anyr, win, blk, gnt_e, we;
    logic [31:0] a, d;
    logic [3:0]  b;
    if (!rst_n) begin
      q.delete();
      lw_m   = 1'b1;
      u1_exp = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    end

    if (q.size() != 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk(e.owner ? "m1_rvalid" : "m0_rvalid", e.owner ? m1_rvalid : m0_rvalid, 1);
      chk(e.owner ? "m1_rdata"  : "m0_rdata",  e.owner ? m1_rdata  : m0_rdata,  e.rdata);
      chk(e.owner ? "m1_err"    : "m0_err",    e.owner ? m1_err    : m0_err,    e.err);
      chk("other_rvalid", e.owner ? m0_rvalid : m1_rvalid, 0);
      chk("other_rdata",  e.owner ? m0_rdata  : m1_rdata,  0);
      chk("other_err",    e.owner ? m0_err    : m1_err,    0);
    end else begin
      chk("idle_m0_rvalid", m0_rvalid, 0);
      chk("idle_m1_rvalid", m1_rvalid, 0);
      chk("idle_rdata", m0_rdata | m1_rdata, 0);
      chk("idle_err", {m0_err, m1_err}, 0);
    end

    if (u1_exp) begin
      chk("noprot_rvalid", u1_m0_rvalid, 1);
      chk("noprot_err", u1_m0_err, 0);
    end
    u1_exp = 1'b0;
    if (rst_n && m0_req && m0_we && !core_halted && s_gnt) begin
      chk("noprot_s_req", u1_s_req, 1);
      chk("noprot_gnt", u1_m0_gnt, 1);
      u1_exp = 1'b1;
    end

    anyr  = m0_req | m1_req;
    win   = (m0_req && m1_req) ? ~lw_m : m1_req;
    blk   = anyr && !win && m0_we && !core_halted;
    gnt_e = blk || (anyr && s_gnt);
    we    = win ? m1_we : m0_we;
    a     = win ? m1_addr : m0_addr;
    d     = win ? m1_wdata : m0_wdata;
    b     = win ? m1_be : m0_be;
    chk("s_req", s_req, anyr && !blk);
    chk("m0_gnt", m0_gnt, gnt_e && !win);
    chk("m1_gnt", m1_gnt, gnt_e && win);
    if (anyr && !blk) begin
      chk("s_addr", s_addr, a);
      chk("s_we", s_we, we);
      chk("s_be", s_be, b);
      chk("s_wdata", s_wdata, d);
    end else if (!anyr) begin
      chk("idle_payload", s_addr | s_wdata | {28'h0, s_be} | {31'h0, s_we}, 0);
    end

    if (gnt_e) begin
      e.cyc   = cyc + 1;
      e.owner = win;
      e.blk   = blk;
      e.err   = blk | a[8];
      e.rdata = 32'h0;
      if (!blk) begin
        if (we) begin
          if (!a[8])
            for (int i = 0; i < 4; i++)
              if (b[i]) ref_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
        end else if (!a[8]) begin
          e.rdata = ref_mem[a[7:2]];
        end
      end
      if (rst_n) begin
        q.push_back(e);
        lw_m = win;
      end
    end
    cyc++;
  end

  task automatic drv(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic [3:0] b0, input logic r1, input logic w1, input logic [31:0] a1,
                     input logic [31:0] d1, input logic [3:0] b1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_be = b0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_be = b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention right after reset: m0 first, then m1.
    drv(1, 0, 32'h10, 0, 4'hF, 1, 0, 32'h10, 0, 4'hF);
    drv(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 4'hF);
    idle();

    // Continuous contention alternates grants.
    for (int i = 0; i < 6; i++)
      drv(1, 0, 32'(4 * i), 0, 4'hF, 1, 0, 32'(4 * i + 32), 0, 4'hF);
    idle();

    // Protected host write while running, then read back the old value.
    core_halted = 1'b0;
    drv(1, 1, 32'h04, 32'h12345678, 4'hF, 0, 0, 0, 0, 0);
    drv(1, 0, 32'h04, 0, 4'hF, 0, 0, 0, 0, 0);
    idle();

    // Host write while halted, full and partial byte enables.
    core_halted = 1'b1;
    drv(1, 1, 32'h04, 32'h12345678, 4'hF, 0, 0, 0, 0, 0);
    drv(1, 0, 32'h04, 0, 4'hF, 0, 0, 0, 0, 0);
    drv(1, 1, 32'h08, 32'hCAFEF00D, 4'b0101, 0, 0, 0, 0, 0);
    drv(1, 0, 32'h08, 0, 4'hF, 0, 0, 0, 0, 0);
    idle();

    // core_halted changing after the grant does not alter the issued response.
    core_halted = 1'b0;
    drv(1, 1, 32'h0C, 32'h11112222, 4'hF, 0, 0, 0, 0, 0);
    core_halted = 1'b1;
    idle();
    core_halted = 1'b0;

    // m1 writes and m0 reads are never blocked.
    drv(0, 0, 0, 0, 0, 1, 1, 32'h0C, 32'h33334444, 4'hF);
    drv(1, 0, 32'h0C, 0, 4'hF, 0, 0, 0, 0, 0);

    // RAM stall, then error response routing.
    s_gnt = 1'b0;
    drv(0, 0, 0, 0, 0, 1, 0, 32'h14, 0, 4'hF);
    drv(1, 0, 32'h18, 0, 4'hF, 1, 0, 32'h14, 0, 4'hF);
    s_gnt = 1'b1;
    drv(0, 0, 0, 0, 0, 1, 0, 32'h14, 0, 4'hF);
    drv(0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 4'hF);
    idle();

    // Spurious RAM response with nothing pending is dropped.
    spur = 1'b1;
    idle();
    spur = 1'b0;
    idle();

    // Reset in the response cycle of an m1 access discards it.
    drv(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 4'hF);
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    drv(1, 0, 32'h24, 0, 4'hF, 1, 0, 32'h28, 0, 4'hF);
    idle();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      core_halted = ($urandom_range(0, 2) == 0);
      s_gnt       = ($urandom_range(0, 3) != 0);
      spur        = ($urandom_range(0, 7) == 0);
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {23'h0, 7'($urandom_range(0, 127)), 2'b00},
          $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {23'h0, 7'($urandom_range(0, 127)), 2'b00},
          $urandom, 4'($urandom_range(0, 15)));
    end
    spur = 1'b0;
    s_gnt = 1'b1;
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
